instr_aligner: RTL and testbench
================================

INSTR_ALIGNER -- requirements
Module: instr_aligner

Interface
REQ-001 s_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 s_resetn_i  in  1  reset, synchronous, active-low.
REQ-003 s_flush_i  in  1  discard all held fetch data (pipeline redirect).
REQ-004 s_flush_half_i  in  1  with s_flush_i: new stream starts at upper halfword (target address bit 1 = 1).
REQ-005 s_fe_valid_i  in  1  fetch word valid.
REQ-006 s_fe_instr_i  in  32  word-aligned fetch data.
REQ-007 s_fe_error_i  in  3  fetch status (FETCH_VALID, FETCH_INCER, or error code).
REQ-008 s_fe_pred_i  in  1  prediction made from the instruction ending in this word's upper halfword.
REQ-009 s_fe_ready_o  out  1  word accepted when s_fe_valid_i & s_fe_ready_o.
REQ-010 s_id_valid_o  out  1  aligned instruction valid.
REQ-011 s_id_ready_i  in  1  decode accepts; transfer = s_id_valid_o & s_id_ready_i.
REQ-012 s_instr_o  out  32  aligned instruction; RVC in [15:0], [31:16] don't-care.
REQ-013 s_fetch_error_o  out  3  fetch status for the emitted instruction.
REQ-014 s_align_error_o  out  1  prediction/boundary mismatch on emitted instruction.
REQ-015 s_prediction_o  out  1  prediction attached to emitted instruction.

Function
REQ-016 Holding register R (32b data, 3b error, pred) plus state: EMPTY, EMPTY_SKIP, LO (next instr at R[15:0]), HI (next instr at R[31:16]).
REQ-017 RVC detect: halfword[1:0] != 2'b11.
REQ-018 LO, RVC: emit R[15:0]; on transfer -> HI; s_prediction_o = 0.
REQ-019 LO, RVI: emit R; on transfer -> EMPTY, or LO with new word if accepted same cycle; s_prediction_o = R.pred.
REQ-020 HI, RVC: emit R[31:16]; on transfer -> EMPTY/LO as REQ-019; s_prediction_o = R.pred.
REQ-021 HI, RVI: emit {s_fe_instr_i[15:0], R[31:16]} only when s_fe_valid_i; on transfer new word loaded, state HI; s_prediction_o = s_fe_pred_i; s_align_error_o = R.pred.
REQ-022 s_align_error_o = 0 in all other cases.
REQ-023 s_fe_ready_o = ~s_flush_i & (state EMPTY/EMPTY_SKIP, or transfer consumes last halfword of R, or REQ-021 transfer).
REQ-024 EMPTY accepts word -> LO; EMPTY_SKIP accepts word -> HI (lower halfword discarded). No output from EMPTY states (zero-bubble passthrough not required).
REQ-025 R.error not FETCH_VALID/FETCH_INCER: emit one item at current offset with s_fetch_error_o = R.error regardless of RVC/RVI; on transfer -> EMPTY.
REQ-026 REQ-021 split: s_fetch_error_o = R.error if erroneous, else s_fe_error_i.
REQ-027 s_id_valid_o and all outputs held stable while s_id_valid_o & ~s_id_ready_i.
REQ-028 s_flush_i has priority over every transfer: s_id_valid_o = 0, s_fe_ready_o = 0 that cycle; next state EMPTY_SKIP if s_flush_half_i else EMPTY.
REQ-029 Prediction from a word whose RVC lower halfword is emitted in LO is never flagged (REQ-018); upper part follows normally.
REQ-030 No internal counters; latency fetch-accept to first output: 1 cycle.

Reset
REQ-031 While s_resetn_i = 0 at a clock edge: state EMPTY, R cleared to zero, R.error = FETCH_VALID, R.pred = 0.
REQ-032 Reset values: s_id_valid_o 0, s_fe_ready_o 1 (once released), s_instr_o 0, s_fetch_error_o FETCH_VALID, s_align_error_o 0, s_prediction_o 0.
REQ-033 Reset has priority over flush and mid-split data; partially consumed words are dropped.

Structure
REQ-034 FETCH_VALID, FETCH_INCER and fetch-error codes reuse existing p_hardisc definitions; aligner state enum added to p_hardisc.
REQ-035 Single flat module; no sub-module (RVC detect is one comparison).
REQ-036 Outputs connect directly to decoder s_instr_i, s_fetch_error_i, s_align_error_i, s_prediction_i.

Verification
REQ-037 Words 0x00130013 (RVI addi) then 0x45014501: outputs 0x00130013, then 0x4501, 0x4501; ready back-pressure 1 cycle each.
REQ-038 Split RVI: word 0x00934501 then 0xXXXX0513 -> 0x4501, then 0x05130093 emitted in HI with second word loaded, state HI.
REQ-039 Split with pred=1 on first word -> split RVI emitted with s_align_error_o = 1, s_prediction_o = second word's pred.
REQ-040 Error word (s_fe_error_i != FETCH_VALID/INCER, e.g. 3'b010) in LO -> single item, s_fetch_error_o = 3'b010, next state EMPTY.
REQ-041 s_flush_i+s_flush_half_i while in HI, then word 0x45010013 -> lower half dropped, output 0x4501.
REQ-042 s_id_ready_i = 0 for 3 cycles on split RVI -> outputs stable, no fetch accept; reset asserted mid-stall -> s_id_valid_o = 0 next cycle.

Source files
------------

// File: rtl/p_hardisc.sv
// Shared core definitions: fetch status codes, aligner state and holding-register
// layout, plus the halfword decode helpers used by the instruction aligner.
package p_hardisc;

  localparam logic [2:0] FETCH_VALID = 3'b000;
  localparam logic [2:0] FETCH_INCER = 3'b001;

  typedef enum logic [1:0] {
    AL_EMPTY,
    AL_EMPTY_SKIP,
    AL_LO,
    AL_HI
  } al_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  error;
    logic        pred;
  } al_hold_t;

  function automatic logic is_rvc(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  // INCER words still carry usable instructions; every other non-valid code is fatal
  function automatic logic is_fetch_err(input logic [2:0] e);
    return (e != FETCH_VALID) && (e != FETCH_INCER);
  endfunction

endpackage

// File: rtl/instr_aligner_if.sv
// Fetch-to-decode bus of the instruction aligner; master is the aligner itself,
// slave is the surrounding fetch/decode environment.
interface instr_aligner_if;

  logic        s_flush_i;
  logic        s_flush_half_i;
  logic        s_fe_valid_i;
  logic [31:0] s_fe_instr_i;
  logic [2:0]  s_fe_error_i;
  logic        s_fe_pred_i;
  logic        s_fe_ready_o;
  logic        s_id_valid_o;
  logic        s_id_ready_i;
  logic [31:0] s_instr_o;
  logic [2:0]  s_fetch_error_o;
  logic        s_align_error_o;
  logic        s_prediction_o;

  modport master (
    input  s_flush_i, s_flush_half_i, s_fe_valid_i, s_fe_instr_i, s_fe_error_i,
           s_fe_pred_i, s_id_ready_i,
    output s_fe_ready_o, s_id_valid_o, s_instr_o, s_fetch_error_o,
           s_align_error_o, s_prediction_o
  );

  modport slave (
    output s_flush_i, s_flush_half_i, s_fe_valid_i, s_fe_instr_i, s_fe_error_i,
           s_fe_pred_i, s_id_ready_i,
    input  s_fe_ready_o, s_id_valid_o, s_instr_o, s_fetch_error_o,
           s_align_error_o, s_prediction_o
  );

endinterface

// File: rtl/instr_aligner.sv
// Splits word-aligned fetch data into RVC/RVI instructions for decode, stitching
// RVI instructions that straddle two fetch words.
module instr_aligner
  import p_hardisc::*;
(
  input logic             s_clk_i,
  input logic             s_resetn_i,
  instr_aligner_if.master bus
);

  al_state_t   r_state;
  al_hold_t    r_hold;

  logic        w_err, w_lo_rvc, w_hi_rvc, w_split;
  logic        w_valid, w_last, w_xfer, w_ready, w_acc;
  logic [31:0] w_instr;
  logic [2:0]  w_ferr;
  logic        w_align, w_pred;

  assign w_err    = is_fetch_err(r_hold.error);
  assign w_lo_rvc = is_rvc(r_hold.data[15:0]);
  assign w_hi_rvc = is_rvc(r_hold.data[31:16]);
  assign w_split  = (r_state == AL_HI) & ~w_err & ~w_hi_rvc;

  // w_last: this transfer frees R, so a new word may be taken in the same cycle
  always_comb begin
    w_valid = 1'b0;
    w_instr = '0;
    w_ferr  = FETCH_VALID;
    w_align = 1'b0;
    w_pred  = 1'b0;
    w_last  = 1'b0;
    unique case (r_state)
      AL_LO: begin
        w_valid = 1'b1;
        w_ferr  = r_hold.error;
        if (w_err) begin
          w_instr = r_hold.data;
        end else if (w_lo_rvc) begin
          w_instr = {16'h0, r_hold.data[15:0]};
        end else begin
          w_instr = r_hold.data;
          w_pred  = r_hold.pred;
          w_last  = 1'b1;
        end
      end
      AL_HI: begin
        w_ferr = r_hold.error;
        if (w_err) begin
          w_valid = 1'b1;
          w_instr = {16'h0, r_hold.data[31:16]};
        end else if (w_hi_rvc) begin
          w_valid = 1'b1;
          w_instr = {16'h0, r_hold.data[31:16]};
          w_pred  = r_hold.pred;
          w_last  = 1'b1;
        end else begin
          // straddling RVI: the prediction belongs to the word it ends in
          w_valid = bus.s_fe_valid_i;
          w_instr = {bus.s_fe_instr_i[15:0], r_hold.data[31:16]};
          w_pred  = bus.s_fe_pred_i;
          w_align = r_hold.pred;
          if (r_hold.error == FETCH_VALID) w_ferr = bus.s_fe_error_i;
        end
      end
      default: ;
    endcase
    if (bus.s_flush_i) w_valid = 1'b0;
  end

  assign w_xfer  = w_valid & bus.s_id_ready_i;
  assign w_ready = ~bus.s_flush_i &
                   ((r_state == AL_EMPTY) | (r_state == AL_EMPTY_SKIP) |
                    (w_xfer & (w_last | w_split)));
  assign w_acc   = bus.s_fe_valid_i & w_ready;

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      r_state <= AL_EMPTY;
      r_hold  <= '{data: 32'h0, error: FETCH_VALID, pred: 1'b0};
    end else if (bus.s_flush_i) begin
      r_state <= bus.s_flush_half_i ? AL_EMPTY_SKIP : AL_EMPTY;
    end else begin
      if (w_acc)
        r_hold <= '{data: bus.s_fe_instr_i, error: bus.s_fe_error_i, pred: bus.s_fe_pred_i};
      unique case (r_state)
        AL_EMPTY:      if (w_acc) r_state <= AL_LO;
        AL_EMPTY_SKIP: if (w_acc) r_state <= AL_HI;
        AL_LO: if (w_xfer) begin
          if (w_err)         r_state <= AL_EMPTY;
          else if (w_lo_rvc) r_state <= AL_HI;
          else               r_state <= w_acc ? AL_LO : AL_EMPTY;
        end
        AL_HI: if (w_xfer) begin
          if (w_err)         r_state <= AL_EMPTY;
          else if (w_hi_rvc) r_state <= w_acc ? AL_LO : AL_EMPTY;
        end
        default: r_state <= AL_EMPTY;
      endcase
    end
  end

  assign bus.s_fe_ready_o    = w_ready;
  assign bus.s_id_valid_o    = w_valid;
  assign bus.s_instr_o       = w_instr;
  assign bus.s_fetch_error_o = w_ferr;
  assign bus.s_align_error_o = w_align;
  assign bus.s_prediction_o  = w_pred;

endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: directed scenarios plus a randomized stream checked
// against a halfword-queue reference model.
module tb_instr_aligner;
  import p_hardisc::*;

  localparam int NW = 150;

  typedef struct {
    logic [15:0] h;
    logic [2:0]  e;
    logic        p;
    logic        up;
  } hw_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fe;
    logic        al;
    logic        pr;
    logic        rvc;
    logic        iserr;
  } item_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_aligner_if bus();

  instr_aligner dut (
    .s_clk_i    (clk),
    .s_resetn_i (rstn),
    .bus        (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.s_flush_i      = 1'b0;
    bus.s_flush_half_i = 1'b0;
    bus.s_fe_valid_i   = 1'b0;
    bus.s_fe_instr_i   = '0;
    bus.s_fe_error_i   = FETCH_VALID;
    bus.s_fe_pred_i    = 1'b0;
    bus.s_id_ready_i   = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] d, input logic [2:0] e, input logic p);
    bus.s_fe_valid_i = 1'b1;
    bus.s_fe_instr_i = d;
    bus.s_fe_error_i = e;
    bus.s_fe_pred_i  = p;
  endtask

  task automatic test_reset();
    idle_in();
    rstn = 1'b0;
    put_word(32'h4501_4501, FETCH_VALID, 1'b1);
    bus.s_flush_i = 1'b1;
    tick();
    tick();
    idle_in();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_id_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_id_valid got %0b want 0", bus.s_id_valid_o);
    end
    checks++;
    if (bus.s_fe_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_fe_ready got %0b want 1", bus.s_fe_ready_o);
    end
    checks++;
    if (bus.s_instr_o !== 32'h0) begin
      errors++; $display("FAIL reset_instr got %h want 00000000", bus.s_instr_o);
    end
    checks++;
    if (bus.s_fetch_error_o !== FETCH_VALID) begin
      errors++; $display("FAIL reset_fetch_error got %0d want %0d", bus.s_fetch_error_o, FETCH_VALID);
    end
    checks++;
    if ({bus.s_align_error_o, bus.s_prediction_o} !== 2'b00) begin
      errors++; $display("FAIL reset_align_pred got %b want 00", {bus.s_align_error_o, bus.s_prediction_o});
    end
    tick();
  endtask

  // RVI word followed by a word of two RVC instructions
  task automatic test_rvi_rvc();
    idle_in();
    put_word(32'h0013_0013, FETCH_VALID, 1'b0);
    bus.s_id_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_fe_ready_o} !== 2'b01) begin
      errors++; $display("FAIL rvi_rvc_empty got %b want 01", {bus.s_id_valid_o, bus.s_fe_ready_o});
    end
    tick();
    put_word(32'h4501_4501, FETCH_VALID, 1'b0);
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o} !== {2'b11, 32'h0013_0013}) begin
      errors++; $display("FAIL rvi_rvc_rvi got %h want %h",
        {bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o}, {2'b11, 32'h0013_0013});
    end
    tick();
    bus.s_fe_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o[15:0]} !== {2'b10, 16'h4501}) begin
      errors++; $display("FAIL rvi_rvc_lo got %h want %h",
        {bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o[15:0]}, {2'b10, 16'h4501});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o[15:0]} !== {2'b11, 16'h4501}) begin
      errors++; $display("FAIL rvi_rvc_hi got %h want %h",
        {bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o[15:0]}, {2'b11, 16'h4501});
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.s_id_valid_o !== 1'b0) begin
      errors++; $display("FAIL rvi_rvc_drain got %0b want 0", bus.s_id_valid_o);
    end
  endtask

  // RVI straddling two words; p1/p2 are the predictions of the two words
  task automatic test_split(input logic p1, input logic p2);
    idle_in();
    put_word(32'h0093_4501, FETCH_VALID, p1);
    bus.s_id_ready_i = 1'b1;
    tick();
    put_word(32'hABCD_0513, FETCH_VALID, p2);
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o[15:0], bus.s_prediction_o, bus.s_align_error_o}
        !== {2'b10, 16'h4501, 2'b00}) begin
      errors++; $display("FAIL split_lo p1=%0b got %h want %h", p1,
        {bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o[15:0], bus.s_prediction_o, bus.s_align_error_o},
        {2'b10, 16'h4501, 2'b00});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o, bus.s_prediction_o, bus.s_align_error_o}
        !== {2'b11, 32'h0513_0093, p2, p1}) begin
      errors++; $display("FAIL split_rvi p1=%0b p2=%0b got %h want %h", p1, p2,
        {bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o, bus.s_prediction_o, bus.s_align_error_o},
        {2'b11, 32'h0513_0093, p2, p1});
    end
    tick();
    bus.s_fe_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_instr_o[15:0], bus.s_prediction_o, bus.s_align_error_o}
        !== {1'b1, 16'hABCD, p2, 1'b0}) begin
      errors++; $display("FAIL split_tail got %h want %h",
        {bus.s_id_valid_o, bus.s_instr_o[15:0], bus.s_prediction_o, bus.s_align_error_o},
        {1'b1, 16'hABCD, p2, 1'b0});
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.s_id_valid_o !== 1'b0) begin
      errors++; $display("FAIL split_drain got %0b want 0", bus.s_id_valid_o);
    end
  endtask

  task automatic test_error();
    idle_in();
    put_word(32'h0013_0013, 3'b010, 1'b0);
    bus.s_id_ready_i = 1'b1;
    tick();
    bus.s_fe_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_fetch_error_o, bus.s_align_error_o} !== {1'b1, 3'b010, 1'b0}) begin
      errors++; $display("FAIL error_item got %b want %b",
        {bus.s_id_valid_o, bus.s_fetch_error_o, bus.s_align_error_o}, {1'b1, 3'b010, 1'b0});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_fe_ready_o} !== 2'b01) begin
      errors++; $display("FAIL error_empty got %b want 01", {bus.s_id_valid_o, bus.s_fe_ready_o});
    end
  endtask

  task automatic test_flush_half();
    idle_in();
    put_word(32'h4501_4501, FETCH_VALID, 1'b0);
    bus.s_id_ready_i = 1'b1;
    tick();
    bus.s_fe_valid_i = 1'b0;
    tick();
    bus.s_flush_i      = 1'b1;
    bus.s_flush_half_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_fe_ready_o} !== 2'b00) begin
      errors++; $display("FAIL flush_block got %b want 00", {bus.s_id_valid_o, bus.s_fe_ready_o});
    end
    tick();
    bus.s_flush_i      = 1'b0;
    bus.s_flush_half_i = 1'b0;
    put_word(32'h4501_0013, FETCH_VALID, 1'b0);
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_fe_ready_o} !== 2'b01) begin
      errors++; $display("FAIL flush_skip_accept got %b want 01", {bus.s_id_valid_o, bus.s_fe_ready_o});
    end
    tick();
    bus.s_fe_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.s_id_valid_o, bus.s_instr_o[15:0]} !== {1'b1, 16'h4501}) begin
      errors++; $display("FAIL flush_upper got %h want %h",
        {bus.s_id_valid_o, bus.s_instr_o[15:0]}, {1'b1, 16'h4501});
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.s_id_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_drain got %0b want 0", bus.s_id_valid_o);
    end
  endtask

  task automatic test_stall_reset();
    idle_in();
    put_word(32'h0093_4501, FETCH_VALID, 1'b0);
    bus.s_id_ready_i = 1'b1;
    tick();
    put_word(32'hABCD_0513, FETCH_VALID, 1'b0);
    tick();
    bus.s_id_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o} !== {2'b10, 32'h0513_0093}) begin
        errors++; $display("FAIL stall_hold_%0d got %h want %h", i,
          {bus.s_id_valid_o, bus.s_fe_ready_o, bus.s_instr_o}, {2'b10, 32'h0513_0093});
      end
      tick();
    end
    rstn = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (bus.s_id_valid_o !== 1'b0) begin
      errors++; $display("FAIL stall_reset got %0b want 0", bus.s_id_valid_o);
    end
    idle_in();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] wd [NW];
    logic [2:0]  we [NW];
    logic        wp [NW];
    item_t       obs[$];
    item_t       exp_q[$];
    hw_t         hq[$];
    int          widx = 0;
    int          idle = 0;
    int          cyc = 0;
    logic        acc = 1'b0;
    logic        stalled = 1'b0;
    logic [37:0] held = '0;
    for (int i = 0; i < NW; i++) begin
      logic [15:0] lo, hi;
      lo = 16'($urandom);
      hi = 16'($urandom);
      if ($urandom_range(0, 1) == 1) lo[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) hi[1:0] = 2'b11;
      case ($urandom_range(0, 15))
        0:       we[i] = 3'($urandom_range(2, 7));
        1:       we[i] = FETCH_INCER;
        default: we[i] = FETCH_VALID;
      endcase
      if (we[i] == FETCH_INCER) hi[1:0] = 2'b01;
      wd[i] = {hi, lo};
      wp[i] = 1'($urandom_range(0, 1));
    end
    idle_in();
    while (idle < 20 && cyc < 6000) begin
      if (acc) widx++;
      if (widx < NW) begin
        if (!bus.s_fe_valid_i || acc) bus.s_fe_valid_i = ($urandom_range(0, 3) != 0);
        bus.s_fe_instr_i = wd[widx];
        bus.s_fe_error_i = we[widx];
        bus.s_fe_pred_i  = wp[widx];
        bus.s_id_ready_i = ($urandom_range(0, 2) != 0);
      end else begin
        bus.s_fe_valid_i = 1'b0;
        bus.s_id_ready_i = 1'b1;
        idle++;
      end
      @(negedge clk);
      if (stalled) begin
        checks++;
        if ({bus.s_id_valid_o, bus.s_instr_o, bus.s_fetch_error_o, bus.s_align_error_o, bus.s_prediction_o} !== held) begin
          errors++; $display("FAIL random_stall_stable got %h want %h",
            {bus.s_id_valid_o, bus.s_instr_o, bus.s_fetch_error_o, bus.s_align_error_o, bus.s_prediction_o}, held);
        end
      end
      acc     = bus.s_fe_valid_i & bus.s_fe_ready_o;
      stalled = bus.s_id_valid_o & ~bus.s_id_ready_i;
      held    = {bus.s_id_valid_o, bus.s_instr_o, bus.s_fetch_error_o, bus.s_align_error_o, bus.s_prediction_o};
      if (bus.s_id_valid_o & bus.s_id_ready_i)
        obs.push_back('{instr: bus.s_instr_o, fe: bus.s_fetch_error_o, al: bus.s_align_error_o,
                        pr: bus.s_prediction_o, rvc: 1'b0, iserr: 1'b0});
      tick();
      cyc++;
    end
    checks++;
    if (widx < NW) begin
      errors++; $display("FAIL random_timeout got %0d words want %0d", widx, NW);
    end

    // reference: walk the fetched stream as a queue of halfwords
    for (int i = 0; i < NW; i++) begin
      hq.push_back('{h: wd[i][15:0],  e: we[i], p: wp[i], up: 1'b0});
      hq.push_back('{h: wd[i][31:16], e: we[i], p: wp[i], up: 1'b1});
    end
    while (hq.size() > 0) begin
      hw_t   a, b;
      item_t it;
      a  = hq[0];
      it = '{instr: 32'h0, fe: 3'b000, al: 1'b0, pr: 1'b0, rvc: 1'b0, iserr: 1'b0};
      if (a.e != FETCH_VALID && a.e != FETCH_INCER) begin
        it.iserr = 1'b1;
        it.instr = {16'h0, a.h};
        it.fe    = a.e;
        void'(hq.pop_front());
        if (!a.up) void'(hq.pop_front());
      end else if (a.h[1:0] != 2'b11) begin
        it.rvc   = 1'b1;
        it.instr = {16'h0, a.h};
        it.fe    = a.e;
        it.pr    = a.up ? a.p : 1'b0;
        void'(hq.pop_front());
      end else begin
        if (hq.size() < 2) break;
        b        = hq[1];
        it.instr = {b.h, a.h};
        if (a.up) begin
          it.pr = b.p;
          it.al = a.p;
          it.fe = (a.e != FETCH_VALID) ? a.e : b.e;
        end else begin
          it.pr = a.p;
          it.fe = a.e;
        end
        void'(hq.pop_front());
        void'(hq.pop_front());
      end
      exp_q.push_back(it);
    end

    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      item_t e, o;
      logic  ok;
      e  = exp_q[i];
      o  = obs[i];
      ok = (o.fe === e.fe) && (o.al === e.al) && (e.iserr || (o.pr === e.pr)) &&
           ((e.rvc || e.iserr) ? (o.instr[15:0] === e.instr[15:0]) : (o.instr === e.instr));
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random_item_%0d got instr=%h ferr=%0d al=%0b pr=%0b want instr=%h ferr=%0d al=%0b pr=%0b",
          i, o.instr, o.fe, o.al, o.pr, e.instr, e.fe, e.al, e.pr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rvi_rvc();
    test_split(1'b0, 1'b1);
    test_split(1'b1, 1'b0);
    test_error();
    test_flush_half();
    test_stall_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
